branch_predict_unit: RTL and testbench

//   Parametrised branch target buffer (BTB) with 2-bit-style saturating direction counters for the IF stage of the pipelined CPU.

---
 rtl/branch_predict_unit.sv | 131 +++++++++++++
 tb/tb_branch_predict_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// Branch target buffer with saturating direction counters for the fetch stage.
// Lookup and mispredict detection are combinational; training and statistics are registered.
module branch_predict_unit #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_is_jump,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_tk,
    input  logic [ADDR_W-1:0] upd_pred_tgt,
    output logic              mispredict,
    output logic [ADDR_W-1:0] redirect_pc,
    input  logic              inv_all,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_lookup,
    output logic [STAT_W-1:0] stat_misp
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_WT   = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_WNT  = CNT_WT - CNT_W'(1);
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    function automatic logic [CNT_W-1:0] cntInc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] cntDec(input logic [CNT_W-1:0] c);
        return (c == '0) ? c : c - CNT_W'(1);
    endfunction

    function automatic logic [STAT_W-1:0] statNext(input logic [STAT_W-1:0] s,
                                                   input logic clr, input logic inc);
        if (clr)
            return '0;
        else if (inc && s != STAT_MAX)
            return s + STAT_W'(1);
        else
            return s;
    endfunction

    logic [ENTRIES-1:0] entValid;
    logic [TAG_W-1:0]   entTag    [ENTRIES];
    logic [ADDR_W-1:0]  entTarget [ENTRIES];
    logic [CNT_W-1:0]   entCnt    [ENTRIES];

    logic [IDX_W-1:0] lkIdx, upIdx;
    logic [TAG_W-1:0] lkTag, upTag;
    logic             updHit, updAlloc, updTrain, updWrTarget;
    logic [CNT_W-1:0] newCnt;

    assign lkIdx = if_pc[IDX_W+1:2];
    assign lkTag = if_pc[ADDR_W-1:IDX_W+2];
    assign upIdx = upd_pc[IDX_W+1:2];
    assign upTag = upd_pc[ADDR_W-1:IDX_W+2];

    // Lookup sees the table as it was before any same-cycle training.
    always_comb begin
        pred_hit    = entValid[lkIdx] && (entTag[lkIdx] == lkTag);
        pred_taken  = pred_hit && entCnt[lkIdx][CNT_W-1];
        pred_target = pred_taken ? entTarget[lkIdx] : if_pc + ADDR_W'(4);
    end

    always_comb begin
        mispredict  = upd_valid && ((upd_taken != upd_pred_tk) ||
                                    (upd_taken && (upd_target != upd_pred_tgt)));
        redirect_pc = upd_taken ? upd_target : upd_pc + ADDR_W'(4);
    end

    always_comb begin
        updHit      = entValid[upIdx] && (entTag[upIdx] == upTag);
        updTrain    = upd_valid && updHit && !inv_all;
        updAlloc    = upd_valid && !updHit && upd_taken && !inv_all;
        updWrTarget = updAlloc || (updTrain && upd_taken);
        newCnt      = entCnt[upIdx];
        if (upd_is_jump)
            newCnt = CNT_MAX;
        else if (updHit)
            newCnt = upd_taken ? cntInc(entCnt[upIdx]) : cntDec(entCnt[upIdx]);
        else
            newCnt = CNT_WT;
    end

    // Valid bits and counters carry history, so they are cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entValid <= '0;
            for (int i = 0; i < ENTRIES; i++)
                entCnt[i] <= CNT_WNT;
        end else if (inv_all) begin
            entValid <= '0;
        end else if (updAlloc || updTrain) begin
            entValid[upIdx] <= 1'b1;
            entCnt[upIdx]   <= newCnt;
        end
    end

    // Tags and targets are meaningless while the valid bit is clear.
    always_ff @(posedge clk) begin
        if (updWrTarget)
            entTarget[upIdx] <= upd_target;
        if (updAlloc)
            entTag[upIdx] <= upTag;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_lookup <= '0;
            stat_misp   <= '0;
        end else begin
            stat_lookup <= statNext(stat_lookup, stat_clr, if_valid);
            stat_misp   <= statNext(stat_misp, stat_clr, mispredict);
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: table-level reference model checked every cycle,
// plus literal expectations at the directed-scenario points.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_pc = 32'h0040_0010;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_is_jump = 1'b0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_pred_tk = 1'b0;
    logic [31:0] upd_pred_tgt = '0;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        inv_all = 1'b0;
    logic        stat_clr = 1'b0;
    logic [3:0]  stat_lookup, stat_misp;

    int checks = 0;
    int errors = 0;

    branch_predict_unit #(.ADDR_W(32), .ENTRIES(16), .CNT_W(2), .STAT_W(4)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_tk(upd_pred_tk),
        .upd_pred_tgt(upd_pred_tgt), .mispredict(mispredict), .redirect_pc(redirect_pc),
        .inv_all(inv_all), .stat_clr(stat_clr), .stat_lookup(stat_lookup), .stat_misp(stat_misp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: entry contents as plain integers, counter range 0..3, stats 0..15.
    bit          mValid  [16] = '{default: 1'b0};
    int unsigned mTag    [16] = '{default: 0};
    logic [31:0] mTarget [16] = '{default: 32'h0};
    int          mCnt    [16] = '{default: 1};
    int          mLookups = 0;
    int          mMisps   = 0;

    function automatic bit expMisp();
        return upd_valid && ((upd_taken != upd_pred_tk) || (upd_taken && upd_target != upd_pred_tgt));
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                mValid[i] <= 1'b0;
                mCnt[i]   <= 1;
            end
            mLookups <= 0;
            mMisps   <= 0;
        end else begin
            int ui;
            bit hit;
            ui  = int'((upd_pc >> 2) % 16);
            hit = mValid[ui] && mTag[ui] == (upd_pc >> 6);
            if (inv_all) begin
                for (int i = 0; i < 16; i++) mValid[i] <= 1'b0;
            end else if (upd_valid && hit) begin
                if (upd_is_jump) mCnt[ui] <= 3;
                else if (upd_taken) mCnt[ui] <= (mCnt[ui] < 3) ? mCnt[ui] + 1 : 3;
                else mCnt[ui] <= (mCnt[ui] > 0) ? mCnt[ui] - 1 : 0;
                if (upd_taken) mTarget[ui] <= upd_target;
            end else if (upd_valid && upd_taken) begin
                mValid[ui]  <= 1'b1;
                mTag[ui]    <= upd_pc >> 6;
                mTarget[ui] <= upd_target;
                mCnt[ui]    <= upd_is_jump ? 3 : 2;
            end
            mLookups <= stat_clr ? 0 : (if_valid ? ((mLookups < 15) ? mLookups + 1 : 15) : mLookups);
            mMisps   <= stat_clr ? 0 : (expMisp() ? ((mMisps < 15) ? mMisps + 1 : 15) : mMisps);
        end
    end

    always @(negedge clk) begin
        int li;
        bit eHit, eTk;
        li   = int'((if_pc >> 2) % 16);
        eHit = mValid[li] && mTag[li] == (if_pc >> 6);
        eTk  = eHit && mCnt[li] >= 2;
        chk("model pred_hit", 32'(pred_hit), 32'(eHit));
        chk("model pred_taken", 32'(pred_taken), 32'(eTk));
        chk("model pred_target", pred_target, eTk ? mTarget[li] : if_pc + 32'd4);
        chk("model mispredict", 32'(mispredict), 32'(expMisp()));
        if (expMisp())
            chk("model redirect_pc", redirect_pc, upd_taken ? upd_target : upd_pc + 32'd4);
        chk("model stat_lookup", 32'(stat_lookup), 32'(mLookups));
        chk("model stat_misp", 32'(stat_misp), 32'(mMisps));
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input bit jmp, input bit tk, input logic [31:0] tgt,
                       input bit ptk, input logic [31:0] ptgt);
        upd_valid = 1'b1; upd_pc = pc; upd_is_jump = jmp; upd_taken = tk;
        upd_target = tgt; upd_pred_tk = ptk; upd_pred_tgt = ptgt;
    endtask

    task automatic look(input string nm, input bit h, input bit t, input logic [31:0] tg);
        #1;
        chk({nm, " hit"}, 32'(pred_hit), 32'(h));
        chk({nm, " taken"}, 32'(pred_taken), 32'(t));
        chk({nm, " target"}, pred_target, tg);
    endtask

    initial begin
        // Reset state
        if_valid = 1'b1;
        step(2);
        look("reset", 1'b0, 1'b0, 32'h0040_0014);
        chk("reset stat_lookup", 32'(stat_lookup), 32'd0);
        chk("reset stat_misp", 32'(stat_misp), 32'd0);
        rst = 1'b1;
        step();

        // Allocation on a taken miss
        upd(32'h0040_0010, 1'b0, 1'b1, 32'h0040_0040, 1'b0, 32'h0);
        #1;
        chk("alloc mispredict", 32'(mispredict), 32'd1);
        chk("alloc redirect", redirect_pc, 32'h0040_0040);
        look("alloc same-cycle", 1'b0, 1'b0, 32'h0040_0014);
        step();
        upd_valid = 1'b0;
        look("alloc next", 1'b1, 1'b1, 32'h0040_0040);

        // Hysteresis: 10 -> 01 -> 00 -> 00, then 01, then 10
        upd(32'h0040_0010, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_0040);
        #1;
        chk("nt1 mispredict", 32'(mispredict), 32'd1);
        chk("nt1 redirect", redirect_pc, 32'h0040_0014);
        step();
        look("nt1", 1'b1, 1'b0, 32'h0040_0014);
        upd(32'h0040_0010, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0040_0014);
        step(2);
        upd_valid = 1'b0;
        look("nt3 saturate", 1'b1, 1'b0, 32'h0040_0014);
        upd(32'h0040_0010, 1'b0, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0014);
        step();
        look("tk after floor", 1'b1, 1'b0, 32'h0040_0014);
        step();
        upd_valid = 1'b0;
        look("tk twice", 1'b1, 1'b1, 32'h0040_0040);

        // Aliasing on idx 4
        if_pc = 32'h0040_0050;
        look("alias miss", 1'b0, 1'b0, 32'h0040_0054);
        upd(32'h0040_0050, 1'b0, 1'b1, 32'h0040_0100, 1'b0, 32'h0);
        step();
        upd_valid = 1'b0;
        look("alias replace", 1'b1, 1'b1, 32'h0040_0100);
        if_pc = 32'h0040_0010;
        look("alias evicted", 1'b0, 1'b0, 32'h0040_0014);

        // Jump forces counter to max; one not-taken still predicts taken
        upd(32'h0040_0020, 1'b1, 1'b1, 32'h0040_0200, 1'b0, 32'h0);
        step();
        upd(32'h0040_0020, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_0200);
        if_pc = 32'h0040_0020;
        look("jump pre-update", 1'b1, 1'b1, 32'h0040_0200);
        step();
        upd_valid = 1'b0;
        look("jump hysteresis", 1'b1, 1'b1, 32'h0040_0200);

        // inv_all wins over a same-cycle taken update
        inv_all = 1'b1;
        upd(32'h0040_0030, 1'b0, 1'b1, 32'h0040_0300, 1'b0, 32'h0);
        step();
        inv_all = 1'b0; upd_valid = 1'b0;
        look("inv jump entry", 1'b0, 1'b0, 32'h0040_0024);
        if_pc = 32'h0040_0030;
        look("inv dropped update", 1'b0, 1'b0, 32'h0040_0034);
        if_pc = 32'h0040_0050;
        look("inv alias entry", 1'b0, 1'b0, 32'h0040_0054);

        // Statistics saturation and clear
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        #1;
        chk("clr with if_valid", 32'(stat_lookup), 32'd0);
        chk("clr misp", 32'(stat_misp), 32'd0);
        step(20);
        chk("lookup saturate", 32'(stat_lookup), 32'd15);
        if_valid = 1'b0;
        upd(32'h0040_0080, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_0900);
        step(18);
        upd_valid = 1'b0;
        #1;
        chk("misp saturate", 32'(stat_misp), 32'd15);
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        #1;
        chk("clr lookup", 32'(stat_lookup), 32'd0);
        chk("clr misp2", 32'(stat_misp), 32'd0);

        // Asynchronous reset mid-run
        if_valid = 1'b1;
        upd(32'h0040_0050, 1'b0, 1'b1, 32'h0040_0500, 1'b0, 32'h0);
        step();
        upd_valid = 1'b0;
        step(2);
        look("pre-reset", 1'b1, 1'b1, 32'h0040_0500);
        chk("pre-reset stat", 32'(stat_lookup), 32'd3);
        rst = 1'b0;
        look("async reset", 1'b0, 1'b0, 32'h0040_0054);
        chk("async stat_lookup", 32'(stat_lookup), 32'd0);
        chk("async stat_misp", 32'(stat_misp), 32'd0);
        chk("async mispredict", 32'(mispredict), 32'd0);
        step(2);
        rst = 1'b1;
        step(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
